sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 9 +
 rtl/rr_arbiter2.sv | 28 ++
 rtl/sram_arbiter.sv | 95 +++++++++
 tb/tb_sram_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared sizes and state encoding for the two-port SRAM arbiter.
package sram_arbiter_pkg;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int SRAM_DEPTH = 1024;
  localparam int NUM_REQ    = 2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the last-grant pointer advances only on a transfer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic last;

  // On a tie, favour whichever requester did not win the previous transfer.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         last <= 1'b1;
    else if (|grant) last <= grant[1];
  end
endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto one SRAM port, with optional zero-fill after reset.
module sram_arbiter #(
  parameter int ADDR_W    = sram_arbiter_pkg::ADDR_W,
  parameter int DATA_W    = sram_arbiter_pkg::DATA_W,
  parameter int INIT_ZERO = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  input  logic [1:0][DATA_W-1:0] req_bm,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   init_done,
  output logic                   sram_men,
  output logic                   sram_wen,
  output logic                   sram_ren,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_din,
  output logic [DATA_W-1:0]      sram_bm,
  input  logic [DATA_W-1:0]      sram_dout
);
  import sram_arbiter_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SRAM_DEPTH - 1);

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [1:0]          rsp_q;
  logic [1:0]          grant;
  logic                run, xfer, gi;

  assign run  = (state == ST_RUN) && !rst;
  assign xfer = |grant;
  assign gi   = grant[1];

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .valid (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  // The response register can still hold a bit in a reset cycle; mask it so it is dropped.
  assign rsp_valid = rst ? 2'b00 : rsp_q;
  assign rsp_rdata = (|rsp_valid) ? sram_dout : '0;

  always_comb begin
    sram_men  = 1'b0;
    sram_wen  = 1'b0;
    sram_ren  = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    sram_bm   = '0;
    if (!rst && state == ST_INIT) begin
      sram_men  = 1'b1;
      sram_wen  = 1'b1;
      sram_addr = cnt;
      sram_bm   = '1;
    end else if (xfer) begin
      sram_men  = 1'b1;
      sram_wen  = req_we[gi];
      sram_ren  = !req_we[gi];
      sram_addr = req_addr[gi];
      sram_din  = req_wdata[gi];
      sram_bm   = req_bm[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      cnt       <= '0;
      init_done <= 1'b0;
      rsp_q     <= 2'b00;
    end else begin
      rsp_q <= (xfer && !req_we[gi]) ? grant : 2'b00;
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        default: init_done <= 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench: behavioural SRAM macro, vector table, read-response scoreboard.
module tb_sram_arbiter;
  logic             clk, rst;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][9:0]  req_addr;
  logic [1:0][31:0] req_wdata, req_bm;
  logic [31:0]      rsp_rdata, sram_din, sram_bm, sram_dout;
  logic             init_done, sram_men, sram_wen, sram_ren;
  logic [9:0]       sram_addr;

  sram_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_bm(req_bm),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .sram_men(sram_men), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_bm(sram_bm), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macro: registered read, masked write.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    if (sram_men) begin
      if (sram_wen) mem[sram_addr] <= (mem[sram_addr] & ~sram_bm) | (sram_din & sram_bm);
      if (sram_ren) sram_dout <= mem[sram_addr];
    end
  end

  typedef struct {
    logic [1:0]  v, we;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1, m0, m1;
    logic [1:0]  rdy;
  } vec_t;

  typedef struct { logic id; logic [31:0] data; } rsp_t;

  int          checks = 0, errors = 0;
  logic [31:0] ref_mem [1024];
  rsp_t        sb [$];
  vec_t        tab [21];
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  function automatic vec_t mk(input logic [1:0] v, we, input logic [9:0] a0, a1,
                              input logic [31:0] d0, d1, m0, m1, input logic [1:0] rdy);
    vec_t t;
    t.v = v; t.we = we; t.a0 = a0; t.a1 = a1;
    t.d0 = d0; t.d1 = d1; t.m0 = m0; t.m1 = m1; t.rdy = rdy;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive, then at negedge check the previous read's response and this cycle's grant/pins.
  task automatic step(input vec_t t);
    rsp_t        e;
    logic [1:0]  ev;
    logic [31:0] ed;
    logic        g, x, w;
    logic [9:0]  a;
    logic [31:0] d, m;
    req_valid = t.v; req_we = t.we;
    req_addr[0] = t.a0; req_addr[1] = t.a1;
    req_wdata[0] = t.d0; req_wdata[1] = t.d1;
    req_bm[0] = t.m0; req_bm[1] = t.m1;
    @(negedge clk);
    ev = 2'b00; ed = '0;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      ev = e.id ? 2'b10 : 2'b01;
      ed = e.data;
    end
    check("rsp_valid", rsp_valid, ev);
    check("rsp_rdata", rsp_rdata, ed);
    check("req_ready", req_ready, t.rdy);
    g = t.rdy[1];
    x = |t.rdy;
    w = g ? t.we[1] : t.we[0];
    a = g ? t.a1 : t.a0;
    d = g ? t.d1 : t.d0;
    m = g ? t.m1 : t.m0;
    if (x)
      check("sram_pins", {sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm},
                         {1'b1, w, !w, a, d, m});
    else
      check("sram_pins_idle", {sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm}, '0);
    if (x) begin
      if (w) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
      else   sb.push_back('{id: g, data: ref_mem[a]});
    end
    @(posedge clk); #1;
  endtask

  // Zero-fill walk after reset release; requesters are held valid to prove they are blocked.
  task automatic init_check();
    int bad = 0;
    req_valid = 2'b11;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      if (!(sram_men && sram_wen && !sram_ren && sram_addr == 10'(k) && sram_din == 32'h0 &&
            sram_bm == ONES && req_ready == 2'b00 && !init_done && rsp_valid == 2'b00))
        bad++;
      @(posedge clk); #1;
    end
    check("init_bad_cycles", bad, 0);
    req_valid = 2'b00;
    @(negedge clk);
    check("init_done_at_1024", init_done, 1'b1);
    check("init_pins_off", {sram_men, sram_wen}, 2'b00);
    @(posedge clk); #1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    sram_dout = '0;
    rst = 1'b1; req_valid = 2'b11; req_we = 2'b00;
    req_addr = '0; req_wdata = '0; req_bm = '0;

    tab[0]  = mk(2'b01, 2'b01, 10'h3FF, 10'h0, 32'hDEADBEEF, 0, ONES, 0, 2'b01);
    tab[1]  = mk(2'b01, 2'b00, 10'h3FF, 10'h0, 0, 0, 0, 0, 2'b01);
    tab[2]  = mk(2'b00, 2'b00, 10'h0, 10'h0, 0, 0, 0, 0, 2'b00);
    tab[3]  = mk(2'b10, 2'b10, 10'h0, 10'h055, 0, ONES, 0, 32'h0000FFFF, 2'b10);
    tab[4]  = mk(2'b10, 2'b00, 10'h0, 10'h055, 0, 0, 0, 0, 2'b10);
    tab[5]  = mk(2'b00, 2'b00, 10'h0, 10'h0, 0, 0, 0, 0, 2'b00);
    tab[6]  = mk(2'b01, 2'b01, 10'h010, 10'h0, 32'h11111111, 0, ONES, 0, 2'b01);
    tab[7]  = mk(2'b10, 2'b10, 10'h0, 10'h020, 0, 32'h22222222, 0, ONES, 2'b10);
    tab[8]  = mk(2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 2'b01);
    tab[9]  = mk(2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 2'b10);
    tab[10] = mk(2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 2'b01);
    tab[11] = mk(2'b11, 2'b00, 10'h010, 10'h020, 0, 0, 0, 0, 2'b10);
    tab[12] = mk(2'b00, 2'b11, 10'h3FF, 10'h3FF, ONES, ONES, ONES, ONES, 2'b00);
    tab[13] = mk(2'b11, 2'b01, 10'h030, 10'h010, 32'hA5A5A5A5, 0, ONES, 0, 2'b01);
    tab[14] = mk(2'b11, 2'b00, 10'h030, 10'h010, 0, 0, 0, 0, 2'b10);
    tab[15] = mk(2'b11, 2'b00, 10'h030, 10'h010, 0, 0, 0, 0, 2'b01);
    tab[16] = mk(2'b01, 2'b01, 10'h030, 10'h0, 0, 0, 32'hFF00FF00, 0, 2'b01);
    tab[17] = mk(2'b01, 2'b00, 10'h030, 10'h0, 0, 0, 0, 0, 2'b01);
    tab[18] = mk(2'b00, 2'b00, 10'h0, 10'h0, 0, 0, 0, 0, 2'b00);
    tab[19] = mk(2'b10, 2'b01, 10'h3FF, 10'h030, ONES, 0, ONES, 0, 2'b10);
    tab[20] = mk(2'b00, 2'b00, 10'h0, 10'h0, 0, 0, 0, 0, 2'b00);

    // Reset state with both requesters asking.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", req_ready, 2'b00);
    check("rst_rsp", {rsp_valid, rsp_rdata}, '0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_pins", {sram_men, sram_wen, sram_ren, sram_addr, sram_din, sram_bm}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    init_check();

    for (int i = 0; i < 21; i++) step(tab[i]);

    // One-cycle reset right after a read is accepted: response dropped, fill restarts at 0.
    step(mk(2'b01, 2'b01, 10'h100, 10'h0, 32'h12345678, 0, ONES, 0, 2'b01));
    step(mk(2'b01, 2'b00, 10'h100, 10'h0, 0, 0, 0, 0, 2'b01));
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    check("midrst_rsp_dropped", {rsp_valid, rsp_rdata}, '0);
    check("midrst_ready", req_ready, 2'b00);
    check("midrst_pins", {sram_men, sram_wen, sram_ren, sram_addr}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    init_check();

    // Pointer is back at 1, so requester 0 wins the first tie; old data is gone.
    step(mk(2'b11, 2'b00, 10'h100, 10'h3FF, 0, 0, 0, 0, 2'b01));
    step(mk(2'b11, 2'b00, 10'h100, 10'h3FF, 0, 0, 0, 0, 2'b10));
    step(mk(2'b00, 2'b00, 10'h0, 10'h0, 0, 0, 0, 0, 2'b00));
    step(mk(2'b00, 2'b00, 10'h0, 10'h0, 0, 0, 0, 0, 2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
